// File: rtl/wb_commit_regs.sv
// wb_commit_regs: write-back commit of GPRs, HI/LO, LLbit and retired-write counter
// Define WB_BYPASS_EN to forward the current write-back bus onto the read outputs.
module wb_commit_regs #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              wb_wreg,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic              wb_wspreg,
  input  logic              wb_watomicreg,
  input  logic              wb_atomicreg_wdata,
  input  logic              excp_flush,
  input  logic              re1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              llbit_o,
  output logic [CNT_W-1:0]  commit_cnt
);
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic [DATA_W-1:0] gpr [2**ADDR_W];
  logic [DATA_W-1:0] hi, lo;
  logic              llbit, ll_nxt;
  // a flush kills any reservation, even one being set in the same cycle
  assign ll_nxt = excp_flush ? 1'b0 : wb_watomicreg ? wb_atomicreg_wdata : llbit;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) gpr[i] <= '0;
      hi         <= '0;
      lo         <= '0;
      llbit      <= 1'b0;
      commit_cnt <= '0;
    end else begin
      if (wb_wreg && wb_waddr != '0) gpr[wb_waddr] <= wb_wdata;
      if (wb_wspreg) begin
        hi <= wb_hi;
        lo <= wb_lo;
      end
      llbit <= ll_nxt;
      if (wb_wreg | wb_wspreg | wb_watomicreg) commit_cnt <= commit_cnt + CNT_W'(1);
    end
  end
  always_comb begin
    rdata1  = (!re1 || raddr1 == '0) ? '0 :
              (BYP && wb_wreg && raddr1 == wb_waddr) ? wb_wdata : gpr[raddr1];
    rdata2  = (!re2 || raddr2 == '0) ? '0 :
              (BYP && wb_wreg && raddr2 == wb_waddr) ? wb_wdata : gpr[raddr2];
    hi_o    = (BYP && wb_wspreg) ? wb_hi : hi;
    lo_o    = (BYP && wb_wspreg) ? wb_lo : lo;
    llbit_o = BYP ? ll_nxt : llbit;
  end
endmodule
